// File: rtl/mips_cpu_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_unit_if
// Description : Request/result bundle between the control path and the
//               multiply/divide unit (start/op/operands in, busy/done/HI/LO out).
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_cpu_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_content;
    logic [WIDTH-1:0] rt_content;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control path side: issues requests, observes status and HI/LO.
    modport master (
        output start, op, rs_content, rt_content, flush,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, rs_content, rt_content, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_unit
// Description : Iterative (1 bit/cycle) MULT/MULTU/DIV/DIVU unit with the
//               architectural HI/LO registers and MTHI/MTLO writes.
//               Multiply is shift-add, divide is restoring; signed ops work on
//               magnitudes and fix the sign in a final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input wire                   clk,
    input wire                   reset,
    mips_cpu_muldiv_unit_if.slave bus
);
    localparam int               c_cw       = $clog2(WIDTH);
    localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(WIDTH - 1);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_ph;      // product high half / partial remainder
    logic [WIDTH-1:0] r_pl;      // product low half (multiplier) / dividend->quotient
    logic [WIDTH-1:0] r_b;       // multiplicand / divisor magnitude
    logic             r_neg_q;   // negate product or quotient at FIX
    logic             r_neg_r;   // negate remainder at FIX
    logic             r_is_div;
    logic             r_div0;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Operand magnitudes; op[0]=0 selects the signed variants (MULT, DIV).
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_rs;
    logic [WIDTH-1:0] w_abs_rt;
    assign w_signed = ~bus.op[0];
    assign w_abs_rs = (w_signed && bus.rs_content[WIDTH-1]) ? -bus.rs_content : bus.rs_content;
    assign w_abs_rt = (w_signed && bus.rt_content[WIDTH-1]) ? -bus.rt_content : bus.rt_content;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the {carry, high, low} chain right by one.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring step: bring in the next dividend bit and try to subtract.
    // When the subtract succeeds the true difference fits in WIDTH bits.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    assign w_rem_sh = {r_ph, r_pl[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_b;

    // Sign-corrected results presented at the FIX edge.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    assign w_prod = r_neg_q ? -{r_ph, r_pl} : {r_ph, r_pl};
    assign w_quot = r_neg_q ? -r_pl : r_pl;
    assign w_rem  = r_neg_r ? -r_ph : r_ph;

    // Control FSM and datapath; reset beats flush, flush beats start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            c_op_mult, c_op_multu: begin
                                r_state  <= S_MUL;
                                r_busy   <= 1'b1;
                                r_cnt    <= '0;
                                r_ph     <= '0;
                                r_pl     <= w_abs_rt;
                                r_b      <= w_abs_rs;
                                r_neg_q  <= w_signed & (bus.rs_content[WIDTH-1] ^ bus.rt_content[WIDTH-1]);
                                r_neg_r  <= 1'b0;
                                r_is_div <= 1'b0;
                                r_div0   <= 1'b0;
                            end
                            c_op_div, c_op_divu: begin
                                r_state  <= S_DIV;
                                r_busy   <= 1'b1;
                                r_cnt    <= '0;
                                r_ph     <= '0;
                                r_pl     <= w_abs_rs;
                                r_b      <= w_abs_rt;
                                r_neg_q  <= w_signed & (bus.rs_content[WIDTH-1] ^ bus.rt_content[WIDTH-1]);
                                r_neg_r  <= w_signed & bus.rs_content[WIDTH-1];
                                r_is_div <= 1'b1;
                                r_div0   <= (bus.rt_content == '0);
                            end
                            c_op_mthi: begin
                                r_hi   <= bus.rs_content;
                                r_done <= 1'b1;
                            end
                            c_op_mtlo: begin
                                r_lo   <= bus.rs_content;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_ph  <= w_sum[WIDTH:1];
                    r_pl  <= {w_sum[0], r_pl[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_ph  <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
                    r_pl  <= {r_pl[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // Divide by zero: remainder magnitude is |rs|, so the
                        // sign fix restores the raw dividend into HI.
                        r_hi <= w_rem;
                        r_lo <= r_div0 ? DIV0_LO : w_quot;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_muldiv_unit
// Description : Directed, table-driven bench for mips_cpu_muldiv_unit plus
//               hand-written flush/reset/MTHI/MTLO/ignored-start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_muldiv_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_cpu_muldiv_unit_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one multi-cycle op and wait for done. With junk=1 a different
    // request is held on start for several busy cycles and must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit junk, output logic [31:0] hi_o, output logic [31:0] lo_o,
                          output int lat, output bit busy_ok, output logic busy_at_done);
        bus.start      = 1'b1;
        bus.op         = op;
        bus.rs_content = a;
        bus.rt_content = b;
        tick();
        if (junk) bus.op = 3'd1;
        else      bus.start = 1'b0;
        bus.rs_content = 32'hDEAD_BEEF;
        bus.rt_content = 32'h0BAD_F00D;
        busy_ok = 1'b1;
        lat     = 0;
        while (lat < 100) begin
            if (junk && lat == 5) bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            lat++;
            if (bus.done) break;
        end
        hi_o         = bus.hi;
        lo_o         = bus.lo;
        busy_at_done = bus.busy;
    endtask

    initial begin
        logic [31:0] r_hi_o, r_lo_o, r_hi_prev, r_lo_prev;
        int          lat;
        bit          busy_ok;
        logic        busy_at_done;
        bit          saw_done;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5"};
        vecs[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
        vecs[3]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xm1"};
        vecs[4]  = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_shift"};
        vecs[5]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[6]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[7]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0"};
        vecs[8]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7_by0"};
        vecs[9]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1"};
        vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555, "divu_max_3"};
        vecs[11] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100_7"};
        vecs[12] = '{3'd2, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "div_0_5"};

        bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
        bus.rs_content = '0; bus.rt_content = '0;
        reset = 1'b0;
        tick(); tick();
        chk("reset_hi",   bus.hi,   32'h0);
        chk("reset_lo",   bus.lo,   32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        reset = 1'b1;
        tick();

        // Table of multiply/divide vectors, including latency and busy shape.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r_hi_o, r_lo_o, lat, busy_ok, busy_at_done);
            chk({vecs[i].name, "_hi"},  r_hi_o, vecs[i].hi);
            chk({vecs[i].name, "_lo"},  r_lo_o, vecs[i].lo);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd33);
            chk({vecs[i].name, "_busy"}, {31'b0, busy_ok}, 32'h1);
            chk({vecs[i].name, "_busy_done"}, {31'b0, busy_at_done}, 32'h0);
            tick();
            chk({vecs[i].name, "_done_1cyc"}, {31'b0, bus.done}, 32'h0);
        end

        // MTHI then MTLO back-to-back.
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_content = 32'h0000_1234;
        tick();
        chk("mthi_done", {31'b0, bus.done}, 32'h1);
        chk("mthi_busy", {31'b0, bus.busy}, 32'h0);
        chk("mthi_hi",   bus.hi, 32'h0000_1234);
        bus.op = 3'd5; bus.rs_content = 32'h0000_5678;
        tick();
        chk("mtlo_done", {31'b0, bus.done}, 32'h1);
        chk("mtlo_busy", {31'b0, bus.busy}, 32'h0);
        chk("mtlo_lo",   bus.lo, 32'h0000_5678);
        chk("mtlo_hi",   bus.hi, 32'h0000_1234);

        // Op 6 is ignored.
        bus.op = 3'd6; bus.rs_content = 32'hAAAA_AAAA;
        tick();
        bus.start = 1'b0;
        chk("op6_done", {31'b0, bus.done}, 32'h0);
        chk("op6_busy", {31'b0, bus.busy}, 32'h0);
        chk("op6_hi",   bus.hi, 32'h0000_1234);
        chk("op6_lo",   bus.lo, 32'h0000_5678);

        // MTHI in a flush cycle is dropped.
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_content = 32'hBBBB_BBBB; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_mthi_done", {31'b0, bus.done}, 32'h0);
        chk("flush_mthi_hi",   bus.hi, 32'h0000_1234);

        // Flush a MULT at E0+10.
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_content = 32'hFFFF_FFFD; bus.rt_content = 32'h5;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        chk("flush_no_done", {31'b0, saw_done}, 32'h0);
        chk("flush_hi", bus.hi, 32'h0000_1234);
        chk("flush_lo", bus.lo, 32'h0000_5678);
        run_op(3'd0, 32'h0000_0003, 32'h0000_0005, 1'b0, r_hi_o, r_lo_o, lat, busy_ok, busy_at_done);
        chk("post_flush_hi",  r_hi_o, 32'h0);
        chk("post_flush_lo",  r_lo_o, 32'h0000_000F);
        chk("post_flush_lat", 32'(lat), 32'd33);

        // Start while busy is ignored and not queued.
        tick();
        run_op(3'd3, 32'h0000_0064, 32'h0000_0007, 1'b1, r_hi_o, r_lo_o, lat, busy_ok, busy_at_done);
        chk("busy_start_hi",  r_hi_o, 32'h0000_0002);
        chk("busy_start_lo",  r_lo_o, 32'h0000_000E);
        chk("busy_start_lat", 32'(lat), 32'd33);
        tick();
        chk("busy_start_not_queued", {31'b0, bus.busy}, 32'h0);

        // Reset at E0+5 of a DIV.
        r_hi_prev = bus.hi; r_lo_prev = bus.lo;
        chk("pre_reset_nonzero", {31'b0, (r_hi_prev != 0 || r_lo_prev != 0)}, 32'h1);
        bus.start = 1'b1; bus.op = 3'd2; bus.rs_content = 32'd100; bus.rt_content = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_reset_hi",   bus.hi, 32'h0);
        chk("mid_reset_lo",   bus.lo, 32'h0);
        chk("mid_reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("mid_reset_done", {31'b0, bus.done}, 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        chk("mid_reset_no_done", {31'b0, saw_done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
